alu_wb_buffer: RTL and testbench
================================

ALU_WB_BUFFER -- requirements
Module: alu_wb_buffer

Interface
REQ-001 Parameter WIDTH, default 32, data width of buffered ALU results.
REQ-002 Parameter DEPTH, default 4, entry count; power of two, at least 2.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  ALU result presented this cycle.
REQ-006 in_ready  output  1  buffer can accept a result this cycle.
REQ-007 aluout  input  WIDTH  ALU result data.
REQ-008 zero  input  1  ALU zero flag for this result.
REQ-009 rd  input  5  destination register index.
REQ-010 regwrite  input  1  result is to be written back.
REQ-011 wb_valid  output  1  head entry presented to the register-file write port.
REQ-012 wb_ready  input  1  register file accepts the head entry this cycle.
REQ-013 wb_addr  output  5  head entry destination.
REQ-014 wb_data  output  WIDTH  head entry data.
REQ-015 wb_zero  output  1  head entry zero flag.
REQ-016 fwd_addr  input  5  register index to look up for forwarding.
REQ-017 fwd_hit  output  1  fwd_addr matches a valid buffered entry.
REQ-018 fwd_data  output  WIDTH  data of the youngest matching entry.
REQ-019 count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-020 Accept occurs when in_valid and in_ready are both high at a rising edge.
REQ-021 in_ready SHALL equal (count != DEPTH); no pass-through when full, even if a pop occurs in the same cycle.
REQ-022 An accepted result with regwrite=0 or rd=0 is consumed and discarded; no entry is written, count is unchanged.
REQ-023 An accepted result with regwrite=1 and rd!=0 is written at the tail; the tail pointer advances modulo DEPTH.
REQ-024 Pop occurs when wb_valid and wb_ready are both high at a rising edge; the head pointer advances modulo DEPTH.
REQ-025 wb_valid SHALL equal (count != 0); wb_addr, wb_data and wb_zero reflect the head entry and SHALL be 0 when empty.
REQ-026 Latency: an entry accepted at edge N into an empty buffer is presented with wb_valid=1 in the cycle after edge N.
REQ-027 A simultaneous push and pop leaves count unchanged; both pointers advance.
REQ-028 Head outputs SHALL be held stable while wb_valid=1 and wb_ready=0.
REQ-029 fwd_hit/fwd_data are combinational over the valid entries only, and the youngest match (closest to tail) wins.
REQ-030 fwd_addr=0 SHALL give fwd_hit=0 and fwd_data=0; no match SHALL give fwd_data=0.
REQ-031 An entry being popped in the current cycle still participates in forwarding during that cycle.
REQ-032 The same-cycle incoming result is not forwarded; bypass of aluout is the consumer's responsibility.

Reset
REQ-033 While reset is high at an edge: count, head and tail are cleared to 0 and all entries are invalidated.
REQ-034 During reset, in_valid and wb_ready are ignored.
REQ-035 Reset mid-operation discards buffered entries without presenting them.
REQ-036 After reset: in_ready=1, wb_valid=0, fwd_hit=0, and all data outputs are 0.
REQ-037 Entry data storage need not be cleared.

Structure
REQ-038 A shared package holds the entry record (data, zero, rd) and the constants REG_X0=0 and ADDR_W=5.
REQ-039 The forwarding lookup is one sub-module, wb_fwd_lookup: a combinational youngest-match priority search over the entries.
REQ-040 Storage and the pointer/count logic remain in alu_wb_buffer.

Verification
REQ-041 Reset, then push rd=5 data=0x0000_0007 with wb_ready=0 -> next cycle wb_valid=1, wb_addr=5, wb_data=7, count=1; hold 3 cycles and the outputs stay stable.
REQ-042 Push 4 entries (rd=1..4) with wb_ready=0 -> count=4, in_ready=0; a 5th in_valid is not accepted; raise wb_ready and pop in order 1,2,3,4; count returns to 0.
REQ-043 Push rd=0 data=0xFFFF_FFFF, and push rd=3 with regwrite=0 -> both accepted, count stays 0, wb_valid stays 0.
REQ-044 Push rd=9 data=0x11, then rd=9 data=0x22, with fwd_addr=9 -> fwd_hit=1, fwd_data=0x22; after one pop fwd_data=0x22; after both pops fwd_hit=0.
REQ-045 Buffer at count=2 with in_valid=1 and wb_ready=1 for 10 cycles -> count stays 2, pointers wrap, output order matches input order.
REQ-046 Buffer at count=3, assert reset for one cycle -> count=0, wb_valid=0, in_ready=1, and no stale entry is popped afterwards.

Source files
------------

// File: rtl/alu_wb_buffer_pkg.sv
// Shared types and constants for the ALU write-back buffer.
package alu_wb_buffer_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam logic [ADDR_W-1:0] REG_X0 = '0;

    // Per-entry side information; the WIDTH-dependent data word is paired with this in the buffer.
    typedef struct packed {
        logic              zero;
        logic [ADDR_W-1:0] rd;
    } wb_tag_t;

    // True when a result actually updates an architectural register (x0 writes are dropped).
    function automatic logic is_writeback(input logic regwrite, input logic [ADDR_W-1:0] rd);
        return regwrite && (rd != REG_X0);
    endfunction

endpackage

// File: rtl/wb_fwd_lookup.sv
// Youngest-match forwarding search over the valid buffer entries.
module wb_fwd_lookup
    import alu_wb_buffer_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic [DEPTH-1:0]         entry_valid,
    input  logic [ADDR_W-1:0]        entry_rd   [DEPTH],
    input  logic [WIDTH-1:0]         entry_data [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] head,
    input  logic [ADDR_W-1:0]        lookup_addr,
    output logic                     hit_c,
    output logic [WIDTH-1:0]         data_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest from the head so later matches overwrite earlier ones.
    always_comb begin
        hit_c  = 1'b0;
        data_c = '0;
        idx    = '0;
        if (lookup_addr != REG_X0) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                idx = PTR_W'(head + PTR_W'(k));
                if (entry_valid[idx] && (entry_rd[idx] == lookup_addr)) begin
                    hit_c  = 1'b1;
                    data_c = entry_data[idx];
                end
            end
        end
    end

endmodule

// File: rtl/alu_wb_buffer.sv
// In-order write-back buffer between the ALU and the register-file write port,
// with a forwarding lookup over buffered results.
module alu_wb_buffer
    import alu_wb_buffer_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         aluout,
    input  logic                     zero,
    input  logic [ADDR_W-1:0]        rd,
    input  logic                     regwrite,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [ADDR_W-1:0]        wb_addr,
    output logic [WIDTH-1:0]         wb_data,
    output logic                     wb_zero,
    input  logic [ADDR_W-1:0]        fwd_addr,
    output logic                     fwd_hit,
    output logic [WIDTH-1:0]         fwd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Pointer, occupancy and per-entry valid state.
    logic [PTR_W-1:0] head_q,  head_d;
    logic [PTR_W-1:0] tail_q,  tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;

    // Entry storage; never reset, qualified by valid_q / count_q.
    logic [WIDTH-1:0]  data_q [DEPTH];
    wb_tag_t           tag_q  [DEPTH];
    logic [ADDR_W-1:0] tag_rd [DEPTH];

    logic accept;
    logic push;
    logic pop;
    logic full;
    logic empty;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !full;
    assign wb_valid = !empty;
    assign count    = count_q;

    // Handshake decode: discarded results are accepted but never occupy an entry.
    always_comb begin
        accept = in_valid && !full;
        push   = accept && is_writeback(regwrite, rd);
        pop    = wb_valid && wb_ready;
    end

    // Next-state for pointers, occupancy and valid flags.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (pop) begin
            head_d          = PTR_W'(head_q + PTR_W'(1));
            valid_d[head_q] = 1'b0;
        end
        if (push) begin
            tail_d          = PTR_W'(tail_q + PTR_W'(1));
            valid_d[tail_q] = 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = CNT_W'(count_q + CNT_W'(1));
            2'b01:   count_d = CNT_W'(count_q - CNT_W'(1));
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous reset that also invalidates every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Entry write at the tail; data storage carries no reset.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            data_q[tail_q] <= aluout;
            tag_q[tail_q]  <= '{zero: zero, rd: rd};
        end
    end

    // Head entry presented to the register file, forced to zero when empty.
    always_comb begin
        wb_addr = '0;
        wb_data = '0;
        wb_zero = 1'b0;
        if (wb_valid) begin
            wb_addr = tag_q[head_q].rd;
            wb_data = data_q[head_q];
            wb_zero = tag_q[head_q].zero;
        end
    end

    // Flatten destination indices for the lookup.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            tag_rd[i] = tag_q[i].rd;
        end
    end

    wb_fwd_lookup #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fwd_lookup (
        .entry_valid (valid_q),
        .entry_rd    (tag_rd),
        .entry_data  (data_q),
        .head        (head_q),
        .lookup_addr (fwd_addr),
        .hit_c       (fwd_hit),
        .data_c      (fwd_data)
    );

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Self-checking bench for alu_wb_buffer against a queue-based reference model.
module tb_alu_wb_buffer;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  aluout;
    logic              zero;
    logic [4:0]        rd;
    logic              regwrite;
    logic              wb_valid;
    logic              wb_ready;
    logic [4:0]        wb_addr;
    logic [WIDTH-1:0]  wb_data;
    logic              wb_zero;
    logic [4:0]        fwd_addr;
    logic              fwd_hit;
    logic [WIDTH-1:0]  fwd_data;
    logic [2:0]        count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]       rd;
        logic [WIDTH-1:0] data;
        logic             z;
    } ent_t;

    ent_t mq[$];

    alu_wb_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .aluout   (aluout),
        .zero     (zero),
        .rd       (rd),
        .regwrite (regwrite),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .wb_zero  (wb_zero),
        .fwd_addr (fwd_addr),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data),
        .count    (count)
    );

    always #5 clk = ~clk;

    // Advance one clock and apply the same transfer rules to the model queue.
    task automatic tick();
        bit po, pu;
        po = wb_ready && (mq.size() != 0);
        pu = in_valid && (mq.size() != DEPTH) && regwrite && (rd != 5'd0);
        @(posedge clk);
        if (reset) begin
            mq.delete();
        end else begin
            if (po) void'(mq.pop_front());
            if (pu) mq.push_back('{rd, aluout, zero});
        end
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        aluout   = '0;
        zero     = 1'b0;
        rd       = '0;
        regwrite = 1'b0;
        wb_ready = 1'b0;
        fwd_addr = '0;
    endtask

    task automatic push_one(input logic [4:0] r, input logic [WIDTH-1:0] d);
        in_valid = 1'b1;
        rd       = r;
        aluout   = d;
        regwrite = 1'b1;
        zero     = (d == '0);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        in_valid = 1'b1; rd = 5'd3; regwrite = 1'b1; aluout = 32'hDEAD; wb_ready = 1'b1;
        tick();
        tick();
        idle_inputs();
        reset = 1'b0;
        fwd_addr = 5'd3;
        #1;
        total++; if (count !== 3'd0)  begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
        total++; if ({wb_addr, wb_data, wb_zero} !== '0) begin bad++; $display("FAIL reset_wb_outputs got=%0h/%0h/%b exp=0", wb_addr, wb_data, wb_zero); end
        total++; if (fwd_hit !== 1'b0 || fwd_data !== '0) begin bad++; $display("FAIL reset_fwd got=%b/%0h exp=0/0", fwd_hit, fwd_data); end
    endtask

    task automatic test_single();
        idle_inputs();
        push_one(5'd5, 32'h0000_0007);
        for (int c = 0; c < 4; c++) begin
            total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL single_valid cyc=%0d got=%b exp=1", c, wb_valid); end
            total++; if (wb_addr !== 5'd5 || wb_data !== 32'd7 || wb_zero !== 1'b0) begin bad++; $display("FAIL single_head cyc=%0d got=%0d/%0h/%b exp=5/7/0", c, wb_addr, wb_data, wb_zero); end
            total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count cyc=%0d got=%0d exp=1", c, count); end
            if (c < 3) tick();
        end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        total++; if (count !== 3'd0 || wb_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%0d/%b exp=0/0", count, wb_valid); end
    endtask

    task automatic test_fill_drain();
        idle_inputs();
        for (int i = 1; i <= 4; i++) push_one(5'(i), 32'(i * 32'h101));
        total++; if (count !== 3'd4 || in_ready !== 1'b0) begin bad++; $display("FAIL full_state got=%0d/%b exp=4/0", count, in_ready); end
        in_valid = 1'b1; rd = 5'd7; aluout = 32'h77; regwrite = 1'b1;
        tick();
        total++; if (count !== 3'd4 || wb_addr !== 5'd1) begin bad++; $display("FAIL full_reject got=%0d/%0d exp=4/1", count, wb_addr); end
        wb_ready = 1'b1;
        tick();
        total++; if (count !== 3'd3) begin bad++; $display("FAIL full_no_passthru got=%0d exp=3", count); end
        in_valid = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            total++; if (wb_addr !== 5'(i) || wb_data !== 32'(i * 32'h101)) begin bad++; $display("FAIL drain_order i=%0d got=%0d/%0h exp=%0d/%0h", i, wb_addr, wb_data, i, i * 32'h101); end
            tick();
        end
        wb_ready = 1'b0;
        total++; if (count !== 3'd0 || wb_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%0d/%b exp=0/0", count, wb_valid); end
    endtask

    task automatic test_discard();
        idle_inputs();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL discard_ready got=%b exp=1", in_ready); end
        push_one(5'd0, 32'hFFFF_FFFF);
        in_valid = 1'b1; rd = 5'd3; aluout = 32'h1234; regwrite = 1'b0;
        tick();
        in_valid = 1'b0;
        total++; if (count !== 3'd0 || wb_valid !== 1'b0) begin bad++; $display("FAIL discard_state got=%0d/%b exp=0/0", count, wb_valid); end
        total++; if (wb_data !== '0 || wb_addr !== '0) begin bad++; $display("FAIL discard_outputs got=%0h/%0d exp=0/0", wb_data, wb_addr); end
    endtask

    task automatic test_forward();
        idle_inputs();
        fwd_addr = 5'd9;
        in_valid = 1'b1; rd = 5'd9; aluout = 32'h11; regwrite = 1'b1;
        #1;
        total++; if (fwd_hit !== 1'b0) begin bad++; $display("FAIL fwd_no_bypass got=%b exp=0", fwd_hit); end
        tick();
        aluout = 32'h22;
        tick();
        in_valid = 1'b0;
        total++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h22) begin bad++; $display("FAIL fwd_youngest got=%b/%0h exp=1/22", fwd_hit, fwd_data); end
        fwd_addr = 5'd0;
        #1;
        total++; if (fwd_hit !== 1'b0 || fwd_data !== '0) begin bad++; $display("FAIL fwd_x0 got=%b/%0h exp=0/0", fwd_hit, fwd_data); end
        fwd_addr = 5'd10;
        #1;
        total++; if (fwd_hit !== 1'b0 || fwd_data !== '0) begin bad++; $display("FAIL fwd_miss got=%b/%0h exp=0/0", fwd_hit, fwd_data); end
        fwd_addr = 5'd9;
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        total++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h22) begin bad++; $display("FAIL fwd_after_pop got=%b/%0h exp=1/22", fwd_hit, fwd_data); end
        wb_ready = 1'b1;
        #1;
        total++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h22) begin bad++; $display("FAIL fwd_popping got=%b/%0h exp=1/22", fwd_hit, fwd_data); end
        tick();
        wb_ready = 1'b0;
        total++; if (fwd_hit !== 1'b0 || fwd_data !== '0) begin bad++; $display("FAIL fwd_drained got=%b/%0h exp=0/0", fwd_hit, fwd_data); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] exp_d;
        logic [4:0]       exp_r;
        idle_inputs();
        push_one(5'd20, 32'hA0);
        push_one(5'd21, 32'hA1);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; wb_ready = 1'b1; regwrite = 1'b1;
            rd = 5'($urandom_range(1, 31));
            aluout = $urandom;
            #1;
            exp_r = (mq.size() != 0) ? mq[0].rd : 5'd0;
            exp_d = (mq.size() != 0) ? mq[0].data : '0;
            total++; if (count !== 3'd2) begin bad++; $display("FAIL b2b_count cyc=%0d got=%0d exp=2", c, count); end
            total++; if (wb_addr !== exp_r || wb_data !== exp_d) begin bad++; $display("FAIL b2b_order cyc=%0d got=%0d/%0h exp=%0d/%0h", c, wb_addr, wb_data, exp_r, exp_d); end
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        wb_ready = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL b2b_drain got=%0d exp=0", count); end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        push_one(5'd1, 32'h1);
        push_one(5'd2, 32'h2);
        push_one(5'd3, 32'h3);
        total++; if (count !== 3'd3) begin bad++; $display("FAIL mid_fill got=%0d exp=3", count); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (count !== 3'd0 || wb_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL mid_reset got=%0d/%b/%b exp=0/0/1", count, wb_valid, in_ready); end
        wb_ready = 1'b1;
        fwd_addr = 5'd2;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (wb_valid !== 1'b0 || fwd_hit !== 1'b0) begin bad++; $display("FAIL mid_stale cyc=%0d got=%b/%b exp=0/0", c, wb_valid, fwd_hit); end
            tick();
        end
        wb_ready = 1'b0;
    endtask

    task automatic test_random();
        logic             e_hit;
        logic [WIDTH-1:0] e_fd;
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            reset    = ($urandom_range(0, 49) == 0);
            in_valid = $urandom_range(0, 1);
            wb_ready = ($urandom_range(0, 2) != 0);
            rd       = 5'($urandom_range(0, 7));
            regwrite = ($urandom_range(0, 4) != 0);
            aluout   = $urandom;
            zero     = $urandom_range(0, 1);
            fwd_addr = 5'($urandom_range(0, 7));
            #1;
            e_hit = 1'b0;
            e_fd  = '0;
            if (fwd_addr != 5'd0) begin
                for (int i = int'(mq.size()) - 1; i >= 0; i--) begin
                    if (mq[i].rd == fwd_addr) begin
                        e_hit = 1'b1;
                        e_fd  = mq[i].data;
                        break;
                    end
                end
            end
            total++; if (count !== 3'(mq.size())) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, count, mq.size()); end
            total++; if (in_ready !== (mq.size() != DEPTH)) begin bad++; $display("FAIL rnd_in_ready cyc=%0d got=%b", c, in_ready); end
            total++; if (wb_valid !== (mq.size() != 0)) begin bad++; $display("FAIL rnd_wb_valid cyc=%0d got=%b", c, wb_valid); end
            if (mq.size() != 0) begin
                total++; if (wb_addr !== mq[0].rd || wb_data !== mq[0].data || wb_zero !== mq[0].z) begin bad++; $display("FAIL rnd_head cyc=%0d got=%0d/%0h/%b exp=%0d/%0h/%b", c, wb_addr, wb_data, wb_zero, mq[0].rd, mq[0].data, mq[0].z); end
            end else begin
                total++; if ({wb_addr, wb_data, wb_zero} !== '0) begin bad++; $display("FAIL rnd_empty_head cyc=%0d got=%0d/%0h/%b exp=0", c, wb_addr, wb_data, wb_zero); end
            end
            total++; if (fwd_hit !== e_hit || fwd_data !== e_fd) begin bad++; $display("FAIL rnd_fwd cyc=%0d addr=%0d got=%b/%0h exp=%b/%0h", c, fwd_addr, fwd_hit, fwd_data, e_hit, e_fd); end
            tick();
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_fill_drain();
        test_discard();
        test_forward();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
